// File: rtl/sram_report_reader.sv
// sram_report_reader: reads a LENGTH-byte report from the SRAM user port on
// each poll and serializes it MSB-first onto a valid/ready bit stream.
//
// state | meaning
// IDLE  | waiting for poll; frame_done pulse is cleared here
// FETCH | mem_addr has settled for a cycle; capture mem_data into the shifter
// SHIFT | presenting bits; advance on bit_valid && bit_ready
module sram_report_reader #(
    parameter int START_ADDR = 0,
    parameter int LENGTH     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       poll,
    output logic [4:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic       bit_out,
    output logic       bit_valid,
    input  logic       bit_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [4:0] START     = 5'(START_ADDR);
    localparam logic [4:0] LAST_BYTE = 5'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic [4:0] byte_cnt;

    logic [7:0] shift_next;
    logic [2:0] bit_cnt_next;
    logic [4:0] byte_cnt_next;
    logic [4:0] mem_addr_next;
    logic       bit_out_next;
    logic       bit_valid_next;
    logic       busy_next;
    logic       frame_done_next;

    logic       accept;
    logic       last_bit;
    logic       last_byte;

    assign accept    = bit_valid && bit_ready;
    assign last_bit  = (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == LAST_BYTE);

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= 8'd0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 5'd0;
            mem_addr   <= START;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
            byte_cnt   <= byte_cnt_next;
            mem_addr   <= mem_addr_next;
            bit_out    <= bit_out_next;
            bit_valid  <= bit_valid_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (poll) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                if (accept && last_bit) begin
                    state_next = last_byte ? IDLE : FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next values of the datapath and outputs; everything holds unless a
    // state action below changes it, which keeps bit_out stable while stalled.
    always_comb begin
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt;
        byte_cnt_next   = byte_cnt;
        mem_addr_next   = mem_addr;
        bit_out_next    = bit_out;
        bit_valid_next  = bit_valid;
        busy_next       = busy;
        frame_done_next = frame_done;
        case (state)
            IDLE: begin
                frame_done_next = 1'b0;
                if (poll) begin
                    mem_addr_next = START;
                    byte_cnt_next = 5'd0;
                    busy_next     = 1'b1;
                end
            end
            FETCH: begin
                // The byte is frozen here; later SRAM writes cannot reach it.
                shift_next     = mem_data;
                bit_cnt_next   = 3'd0;
                bit_out_next   = mem_data[7];
                bit_valid_next = 1'b1;
            end
            SHIFT: begin
                if (accept) begin
                    if (!last_bit) begin
                        shift_next   = {shift_reg[6:0], 1'b0};
                        bit_cnt_next = bit_cnt + 3'd1;
                        bit_out_next = shift_reg[6];
                    end else begin
                        bit_valid_next = 1'b0;
                        if (!last_byte) begin
                            byte_cnt_next = byte_cnt + 5'd1;
                            // 5-bit add wraps 31 -> 0 for reports crossing the top.
                            mem_addr_next = mem_addr + 5'd1;
                        end else begin
                            busy_next       = 1'b0;
                            frame_done_next = 1'b1;
                        end
                    end
                end
            end
            default: begin
                frame_done_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_report_reader.sv
// Bench for sram_report_reader: two instances (START 0/LENGTH 8 and
// START 30/LENGTH 4), each with its own SRAM array, checked every cycle
// against a bit-count based model of the frame.
module tb_sram_report_reader;

    localparam int S0 = 0;
    localparam int L0 = 8;
    localparam int S1 = 30;
    localparam int L1 = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] poll  = 2'b00;
    logic [1:0] ready = 2'b00;
    logic [1:0] rmode = 2'b00;
    logic [7:0] mem [2][32];

    wire  [4:0] addr0, addr1;
    wire  [7:0] data0, data1;
    wire  [1:0] bout, bval, busy, done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign data0 = mem[0][addr0];
    assign data1 = mem[1][addr1];

    sram_report_reader #(.START_ADDR(S0), .LENGTH(L0)) u0 (
        .clk(clk), .reset(reset), .poll(poll[0]),
        .mem_addr(addr0), .mem_data(data0),
        .bit_out(bout[0]), .bit_valid(bval[0]), .bit_ready(ready[0]),
        .busy(busy[0]), .frame_done(done[0])
    );

    sram_report_reader #(.START_ADDR(S1), .LENGTH(L1)) u1 (
        .clk(clk), .reset(reset), .poll(poll[1]),
        .mem_addr(addr1), .mem_data(data1),
        .bit_out(bout[1]), .bit_valid(bval[1]), .bit_ready(ready[1]),
        .busy(busy[1]), .frame_done(done[1])
    );

    function automatic int sa(int i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic int ln(int i);
        return (i == 0) ? L0 : L1;
    endfunction

    function automatic int addr_of(int i);
        return (i == 0) ? int'(addr0) : int'(addr1);
    endfunction

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is k accepted bits; byte k/8 is captured the cycle after the
    // previous byte's last bit (or after poll) from (START + k/8) mod 32.
    bit         m_act  [2] = '{0, 0};
    bit         m_pend [2] = '{0, 0};
    bit         m_done [2] = '{0, 0};
    int         m_k    [2] = '{0, 0};
    int         m_addr [2] = '{S0, S1};
    logic [7:0] m_cap  [2][32];
    bit         rdy_s  [2] = '{0, 0};

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            rdy_s[i] = ready[i];
            if (reset) begin
                m_act[i]  = 0;
                m_pend[i] = 0;
                m_done[i] = 0;
                m_k[i]    = 0;
                m_addr[i] = sa(i);
            end else begin
                m_done[i] = 0;
                if (!m_act[i]) begin
                    if (poll[i]) begin
                        m_act[i]  = 1;
                        m_pend[i] = 1;
                        m_k[i]    = 0;
                        m_addr[i] = sa(i);
                    end
                end else if (m_pend[i]) begin
                    m_cap[i][m_k[i] / 8] = mem[i][(sa(i) + m_k[i] / 8) % 32];
                    m_pend[i] = 0;
                end else if (ready[i]) begin
                    m_k[i]++;
                    if (m_k[i] % 8 == 0) begin
                        if (m_k[i] == 8 * ln(i)) begin
                            m_act[i]  = 0;
                            m_done[i] = 1;
                        end else begin
                            m_pend[i] = 1;
                            m_addr[i] = (sa(i) + m_k[i] / 8) % 32;
                        end
                    end
                end
            end
        end
    end

    // ---------------- received stream ----------------
    logic [7:0] rx_q0 [$];
    logic [7:0] rx_q1 [$];
    logic [7:0] rx_sh [2];
    int         rx_n  [2] = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                rx_n[i] = 0;
            end else if (bval[i] && ready[i]) begin
                rx_sh[i] = {rx_sh[i][6:0], bout[i]};
                rx_n[i]++;
                if (rx_n[i] == 8) begin
                    if (i == 0) rx_q0.push_back(rx_sh[i]);
                    else        rx_q1.push_back(rx_sh[i]);
                    rx_n[i] = 0;
                end
            end
        end
    end

    // ---------------- ready generator ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ready[i] = rmode[i] ? 1'($urandom % 2) : 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit  pv   [2] = '{0, 0};
    bit  pb   [2] = '{0, 0};
    int  dcnt [2] = '{0, 0};
    int  aq   [$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy%0d", i), int'(busy[i]), int'(m_act[i]));
            chk($sformatf("valid%0d", i), int'(bval[i]), int'(m_act[i] && !m_pend[i]));
            chk($sformatf("done%0d", i), int'(done[i]), int'(m_done[i]));
            chk($sformatf("addr%0d", i), addr_of(i), m_addr[i]);
            if (m_act[i] && !m_pend[i]) begin
                chk($sformatf("bit%0d", i), int'(bout[i]),
                    int'(m_cap[i][m_k[i] / 8][7 - (m_k[i] % 8)]));
            end
            if (reset) begin
                pv[i] = 0;
            end else begin
                if (pv[i] && !rdy_s[i]) begin
                    chk($sformatf("hold_valid%0d", i), int'(bval[i]), 1);
                    chk($sformatf("hold_bit%0d", i), int'(bout[i]), int'(pb[i]));
                end
                pv[i] = bval[i];
                pb[i] = bout[i];
            end
            if (done[i]) dcnt[i]++;
        end
        if (busy[1] && (aq.size() == 0 || aq[$] != int'(addr1))) aq.push_back(int'(addr1));
    end

    // ---------------- helpers ----------------
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_poll(int i);
        poll[i] = 1'b1;
        @(negedge clk);
        poll[i] = 1'b0;
    endtask

    task automatic wait_done(int i, int lim, string nm);
        int n;
        n = 0;
        while (!done[i] && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (!done[i]) chk({nm, "_timeout"}, n, -1);
    endtask

    task automatic chk_rx(int i, int base, int n, input logic [7:0] exp [8], string nm);
        int sz;
        int got;
        sz = (i == 0) ? rx_q0.size() : rx_q1.size();
        chk({nm, "_count"}, sz - base, n);
        for (int j = 0; j < n; j++) begin
            if (base + j < sz) got = (i == 0) ? int'(rx_q0[base + j]) : int'(rx_q1[base + j]);
            else got = -1;
            chk($sformatf("%s_byte%0d", nm, j), got, int'(exp[j]));
        end
    endtask

    task automatic load_patterns();
        logic [7:0] p [8];
        p = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h01, 8'h80};
        for (int j = 0; j < 8; j++) mem[0][j] = p[j];
        mem[1][30] = 8'h11;
        mem[1][31] = 8'h22;
        mem[1][0]  = 8'h33;
        mem[1][1]  = 8'h44;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat_a [8];
        logic [7:0] pat_b [8];
        int base;
        int abase;
        int n;
        int d0;

        pat_a = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h01, 8'h80};
        pat_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 32; j++) mem[i][j] = 8'($urandom);
        load_patterns();

        #1 reset = 1'b1;
        tick(3);
        chk("rst_addr0", int'(addr0), 0);
        chk("rst_addr1", int'(addr1), 30);
        chk("rst_bit0", int'(bout[0]), 0);
        chk("rst_valid0", int'(bval[0]), 0);
        chk("rst_busy0", int'(busy[0]), 0);
        chk("rst_done0", int'(done[0]), 0);
        #2 reset = 1'b0;
        tick(2);

        // Frame with ready held high: latency, span and bytes.
        base = rx_q0.size();
        pulse_poll(0);
        chk("lat1_busy", int'(busy[0]), 1);
        chk("lat1_valid", int'(bval[0]), 0);
        @(negedge clk);
        chk("lat2_valid", int'(bval[0]), 1);
        chk("lat2_firstbit", int'(bout[0]), 1);
        n = 1;
        while (!done[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("span_first_valid_to_done", n, 72);
        chk("busy_drop_with_done", int'(busy[0]), 0);
        tick(1);
        chk_rx(0, base, 8, pat_a, "frame_ready");

        // Same frame with ready toggling.
        rmode[0] = 1'b1;
        tick(1);
        base = rx_q0.size();
        pulse_poll(0);
        wait_done(0, 2000, "frame_rand");
        tick(1);
        chk_rx(0, base, 8, pat_a, "frame_rand");
        rmode[0] = 1'b0;
        tick(1);

        // Wrapping address sequence.
        base  = rx_q1.size();
        abase = aq.size();
        pulse_poll(1);
        wait_done(1, 200, "wrap");
        tick(1);
        chk("wrap_addr_count", aq.size() - abase, 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("wrap_addr%0d", j),
                (abase + j < aq.size()) ? aq[abase + j] : -1, (30 + j) % 32);
        end
        chk_rx(1, base, 4, pat_b, "wrap");

        // Polls during FETCH/SHIFT are ignored; poll with frame_done is honoured.
        d0 = dcnt[0];
        pulse_poll(0);
        pulse_poll(0);
        tick(5);
        pulse_poll(0);
        wait_done(0, 200, "poll_ignore");
        poll[0] = 1'b1;
        @(negedge clk);
        poll[0] = 1'b0;
        chk("poll_at_done_busy", int'(busy[0]), 1);
        chk("poll_at_done_fetch", int'(bval[0]), 0);
        @(negedge clk);
        chk("poll_at_done_valid", int'(bval[0]), 1);
        wait_done(0, 200, "second_frame");
        tick(1);
        chk("frames_done", dcnt[0] - d0, 2);

        // SRAM rewrite while byte 0 is shifting.
        base = rx_q0.size();
        pulse_poll(0);
        tick(1);
        mem[0][1] = 8'hC3;
        mem[0][0] = 8'h5A;
        wait_done(0, 200, "rewrite");
        tick(1);
        chk("rewrite_byte0", (rx_q0.size() > base) ? int'(rx_q0[base]) : -1, 8'hA5);
        chk("rewrite_byte1", (rx_q0.size() > base + 1) ? int'(rx_q0[base + 1]) : -1, 8'hC3);

        // Random polls, ready and SRAM traffic on both instances.
        rmode = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                poll[i] = ($urandom % 16 == 0);
                if ($urandom % 4 == 0) mem[i][$urandom % 32] = 8'($urandom);
            end
        end
        poll = 2'b00;
        n = 0;
        while ((m_act[0] || m_act[1]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_act[0] || m_act[1]) chk("random_drain_timeout", n, -1);
        rmode = 2'b00;
        load_patterns();
        tick(2);

        // Reset during byte 3 aborts the frame without frame_done.
        d0 = dcnt[0];
        pulse_poll(0);
        tick(30);
        #2 reset = 1'b1;
        #1;
        chk("abort_addr", int'(addr0), 0);
        chk("abort_bit", int'(bout[0]), 0);
        chk("abort_valid", int'(bval[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        tick(2);
        #2 reset = 1'b0;
        tick(3);
        chk("abort_no_done", dcnt[0] - d0, 0);
        base = rx_q0.size();
        pulse_poll(0);
        wait_done(0, 200, "after_abort");
        tick(1);
        chk_rx(0, base, 8, pat_a, "after_abort");

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sram_report_reader.md
# sram_report_reader

Downstream consumer of the I2C-written 32-byte dual-port SRAM. On each `poll` pulse it reads a `LENGTH`-byte report from the SRAM's asynchronous user read port. It serializes the report MSB-first onto a bit-level valid/ready stream for the controller-protocol transmitter. The I2C host can update the SRAM while a frame is being read; each byte is captured atomically at fetch time.

## Interface
- `START_ADDR`, 0: first SRAM byte address of the report (0..31).
- `LENGTH`, 8: report length in bytes (1..32).
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `poll`  in  1  single-cycle request to transmit one report frame.
- `mem_addr`  out  5  SRAM user read address; drives the SRAM user address input.
- `mem_data`  in  8  SRAM user read data; combinational function of `mem_addr`.
- `bit_out`  out  1  current serial bit.
- `bit_valid`  out  1  `bit_out` is valid.
- `bit_ready`  in  1  consumer accepts `bit_out` this cycle.
- `busy`  out  1  high from the cycle after an accepted poll until frame completion.
- `frame_done`  out  1  one-cycle pulse after the last bit is accepted.

## Operation
- All outputs are registered. Reset values: `mem_addr`=START_ADDR, `bit_out`=0, `bit_valid`=0, `busy`=0, `frame_done`=0. State is IDLE; the shift register, bit counter and byte counter are all 0.
- **IDLE**
  - `frame_done`<=0.
  - On `poll`: `mem_addr`<=START_ADDR, byte counter<=0, `busy`<=1, go to FETCH.
- **FETCH**
  - Latch `mem_data` into the 8-bit shift register and set bit counter<=0.
  - `bit_out`<=`mem_data[7]`, `bit_valid`<=1, go to SHIFT.
- **SHIFT**, on `bit_valid && bit_ready`:
  - If bit counter < 7: shift left, bit counter++, `bit_out`<=next MSB.
  - If bit counter = 7 and byte counter < LENGTH-1: `bit_valid`<=0, byte counter++, `mem_addr`<=`mem_addr`+1 (5-bit, wraps 31->0), go to FETCH.
  - If bit counter = 7 and byte counter = LENGTH-1: `bit_valid`<=0, `busy`<=0, `frame_done`<=1, go to IDLE.
  - Without `bit_ready`, every output holds its value.
- `poll` is ignored in FETCH and SHIFT. A `poll` in the same cycle as `frame_done` is high is honoured, because the block is already in IDLE that cycle.
- SRAM writes made during a frame affect only bytes not yet fetched. A fetched byte never changes mid-shift.
- Address arithmetic is modulo 32: byte i is read from (START_ADDR+i) mod 32. Example: START_ADDR=30, LENGTH=4 reads 30, 31, 0, 1.
- Counters: bit counter is 3 bits; byte counter is 5 bits and compares against LENGTH-1.
- Reset asserted mid-frame aborts immediately to reset values. No `frame_done` is issued for the aborted frame.

## Timing
- Poll sampled at edge N: `busy`=1 and FETCH at N+1; first bit presented with `bit_valid`=1 from N+2.
- `mem_addr` is stable for at least one full cycle before FETCH samples `mem_data`, so the SRAM's asynchronous read path has one clock of settling.
- With `bit_ready` held high: 8 bits per byte, one bubble cycle between bytes. A frame then spans 9*LENGTH cycles from the first `bit_valid` to `frame_done`, and `frame_done` rises the cycle after the last bit is accepted.
- Valid/ready rule: once `bit_valid`=1, `bit_valid` and `bit_out` stay unchanged until accepted.
- Minimum poll-to-poll spacing for back-to-back frames is 9*LENGTH+2 cycles.

## Test plan
- SRAM[0..7]=A5,3C,FF,00,81,7E,01,80; poll with `bit_ready`=1 -> 64 bits MSB-first (A5 gives 1010_0101, ...). First valid 2 cycles after poll, one bubble per byte, `frame_done` pulse 72 cycles after the first valid, `busy` drops the same cycle.
- Same frame with `bit_ready` toggling pseudo-randomly -> identical bit sequence, and `bit_out` is never changed while valid and not ready.
- START_ADDR=30, LENGTH=4, SRAM[30]=11, [31]=22, [0]=33, [1]=44 -> `mem_addr` sequence 30, 31, 0, 1; bit stream 11,22,33,44.
- Poll pulses during FETCH and SHIFT -> no effect, exactly one frame. Poll coincident with `frame_done` -> a second frame starts, with FETCH on the next cycle.
- Rewrite SRAM[1] from 3C to C3 while byte 0 is shifting -> C3 transmitted. Rewrite SRAM[0] while byte 0 is shifting -> original A5 transmitted.
- Assert reset during byte 3 -> all outputs take their reset values immediately, no `frame_done`; the next poll restarts cleanly from START_ADDR.
